flash_sample_sequencer: RTL and testbench

Sequences 16-bit audio-sample playback out of the 32-bit flash on the Avalon-MM flash interface. Given a word-address range, it issues one single-word read per address and waits for its data. It splits each returned word into two samples and hands them to the audio path over a valid/ready handshake. It sits between the phoneme/address control logic (`start`, range, `loop`, `stop`) and the flash controller, and is the sole master of the flash read port.

---
 rtl/flash_sample_sequencer.sv | 173 +++++++++++++++++
 tb/tb_flash_sample_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_sequencer.sv
// Plays 16-bit samples from 32-bit flash words over a valid/ready port, one Avalon read per word.
// Define FLASH_SEQ_REVERSE_EN to honour `dir` (reverse address walk and high-half-first samples).
module flash_sample_sequencer #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              dir,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [3:0]        flash_mem_byteenable,
    output logic [6:0]        flash_mem_burstcount,
    output logic [15:0]       sample,
    output logic              sample_valid,
    input  logic              sample_ready
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_DATA, S_EMIT_A, S_EMIT_B, S_ADV
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, start_q, start_d, end_q, end_d;
    logic              loop_q, loop_d, abort_q, abort_d;
    logic              busy_q, busy_d, done_q, done_d, read_q, read_d, valid_q, valid_d;
    logic [15:0]       sample_q, sample_d, hold_q, hold_d;
    logic              abort_now, at_end;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       rd_first, rd_second;

    assign abort_now = abort_q | stop;
    assign at_end    = (addr_q == end_q);

`ifdef FLASH_SEQ_REVERSE_EN
    logic dir_q, dir_d;

    always_comb begin
        dir_d = dir_q;
        if (state_q == S_IDLE && start) dir_d = dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dir_q <= 1'b0;
        else       dir_q <= dir_d;
    end

    assign addr_next = dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    assign rd_first  = dir_q ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
    assign rd_second = dir_q ? flash_mem_readdata[15:0]  : flash_mem_readdata[31:16];
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign addr_next  = addr_q + ADDR_W'(1);
    assign rd_first   = flash_mem_readdata[15:0];
    assign rd_second  = flash_mem_readdata[31:16];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // An abort in REQ/WAIT_DATA still lets the Avalon transaction finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_REQ;
            S_REQ:       if (!flash_mem_waitrequest) state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (flash_mem_readdatavalid) state_d = abort_now ? S_IDLE : S_EMIT_A;
            S_EMIT_A: begin
                if (abort_now)         state_d = S_IDLE;
                else if (sample_ready) state_d = S_EMIT_B;
            end
            S_EMIT_B: begin
                if (abort_now)         state_d = S_IDLE;
                else if (sample_ready) state_d = S_ADV;
            end
            S_ADV: begin
                if (abort_now)             state_d = S_IDLE;
                else if (!at_end || loop_q) state_d = S_REQ;
                else                       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        start_d  = start_q;
        end_d    = end_q;
        loop_d   = loop_q;
        sample_d = sample_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        abort_d  = (state_q != S_IDLE) && abort_now;
        busy_d   = (state_d != S_IDLE);
        read_d   = (state_d == S_REQ);
        valid_d  = (state_d == S_EMIT_A) || (state_d == S_EMIT_B);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_d = start_addr;
                    end_d   = end_addr;
                    loop_d  = loop;
                    addr_d  = start_addr;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    sample_d = rd_first;
                    hold_d   = rd_second;
                end
            end
            S_EMIT_A: if (!abort_now && sample_ready) sample_d = hold_q;
            // done lands in the ADV cycle that decides to return to IDLE
            S_EMIT_B: if (!abort_now && sample_ready && at_end && !loop_q) done_d = 1'b1;
            S_ADV: begin
                if (!abort_now) begin
                    if (!at_end)    addr_d = addr_next;
                    else if (loop_q) addr_d = start_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            loop_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            read_q   <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            hold_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            start_q  <= start_d;
            end_q    <= end_d;
            loop_q   <= loop_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            read_q   <= read_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            hold_q   <= hold_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign flash_mem_burstcount = 7'd1;
    assign sample               = sample_q;
    assign sample_valid         = valid_q;
endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer with a one-cycle-latency Avalon flash model.
module tb_flash_sample_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, stop, loop_i, dir;
    logic [22:0] start_addr, end_addr;
    logic        busy, done, flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        waitreq;
    logic [31:0] rdata = '0;
    logic        rdv = 1'b0;
    logic [3:0]  byteenable;
    logic [6:0]  burstcount;
    logic [15:0] sample;
    logic        sample_valid, sample_ready;

    int checks = 0, errors = 0;
    int accepts = 0, done_cnt = 0;
    logic [15:0] samp_q[$];
    logic [22:0] addr_log[$];

    flash_sample_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop_i), .dir(dir),
        .start_addr(start_addr), .end_addr(end_addr), .busy(busy), .done(done),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_waitrequest(waitreq), .flash_mem_readdata(rdata),
        .flash_mem_readdatavalid(rdv), .flash_mem_byteenable(byteenable),
        .flash_mem_burstcount(burstcount), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mem(input logic [22:0] a);
        case (a)
            23'h10:  mem = 32'hBBBBAAAA;
            23'h11:  mem = 32'hDDDDCCCC;
            23'h20:  mem = 32'h66665555;
            23'h30:  mem = 32'h87654321;
            23'h01:  mem = 32'h22221111;
            23'h00:  mem = 32'h44443333;
            default: mem = {16'hF00D, a[15:0]};
        endcase
    endfunction

    // Flash slave: data returns the cycle after the read is accepted.
    always @(posedge clk) begin
        rdv <= 1'b0;
        if (flash_mem_read && !waitreq) begin
            rdv   <= 1'b1;
            rdata <= mem(flash_mem_address);
            accepts++;
            addr_log.push_back(flash_mem_address);
        end
    end

    always @(posedge clk) begin
        if (sample_valid && sample_ready) samp_q.push_back(sample);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input logic [22:0] s, input logic [22:0] e, input logic lp, input logic d);
        start_addr = s; end_addr = e; loop_i = lp; dir = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin @(negedge clk); n++; end
        chk(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (sample_valid !== 1'b1 && n < max) begin @(negedge clk); n++; end
        chk(tag, 32'(sample_valid), 32'h1);
    endtask

    initial begin
        int s0, a0, d0, l0, s1, a1, n;
        logic all20;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_i = 1'b0; dir = 1'b0;
        start_addr = '0; end_addr = '0; sample_ready = 1'b1; waitreq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_read", 32'(flash_mem_read), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_addr", 32'(flash_mem_address), 0);
        chk("rst_sample", 32'(sample), 0);
        chk("byteenable", 32'(byteenable), 32'hF);
        chk("burstcount", 32'(burstcount), 1);
        reset = 1'b0;
        @(negedge clk);

        // forward two words, ready tied high
        s0 = samp_q.size(); a0 = accepts; d0 = done_cnt; l0 = addr_log.size();
        play(23'h10, 23'h11, 1'b0, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_read", 32'(flash_mem_read), 1);
        chk("t1_addr", 32'(flash_mem_address), 32'h10);
        @(negedge clk);
        chk("t1_read_drop", 32'(flash_mem_read), 0);
        chk("t1_no_valid_yet", 32'(sample_valid), 0);
        @(negedge clk);
        chk("t1_first_valid", 32'(sample_valid), 1);
        chk("t1_first_sample", 32'(sample), 32'hAAAA);
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_at_done", 32'(busy), 1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_nsamp", 32'(samp_q.size() - s0), 4);
        chk("t1_s0", 32'(samp_q[s0]), 32'hAAAA);
        chk("t1_s1", 32'(samp_q[s0+1]), 32'hBBBB);
        chk("t1_s2", 32'(samp_q[s0+2]), 32'hCCCC);
        chk("t1_s3", 32'(samp_q[s0+3]), 32'hDDDD);
        chk("t1_nreads", 32'(accepts - a0), 2);
        chk("t1_a0", 32'(addr_log[l0]), 32'h10);
        chk("t1_a1", 32'(addr_log[l0+1]), 32'h11);
        chk("t1_ndone", 32'(done_cnt - d0), 1);

        // waitrequest stall in REQ
        s0 = samp_q.size(); a0 = accepts; d0 = done_cnt;
        waitreq = 1'b1;
        play(23'h30, 23'h30, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_read_held", 32'(flash_mem_read), 1);
            chk("t2_addr_held", 32'(flash_mem_address), 32'h30);
            @(negedge clk);
        end
        chk("t2_none_accepted", 32'(accepts - a0), 0);
        waitreq = 1'b0;
        wait_idle("t2_idle", 40);
        chk("t2_one_accept", 32'(accepts - a0), 1);
        chk("t2_s0", 32'(samp_q[s0]), 32'h4321);
        chk("t2_s1", 32'(samp_q[s0+1]), 32'h8765);
        chk("t2_ndone", 32'(done_cnt - d0), 1);

        // back-pressure on both halves
        s0 = samp_q.size(); a0 = accepts;
        sample_ready = 1'b0;
        play(23'h10, 23'h11, 1'b0, 1'b0);
        wait_valid("t3_valid", 20);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_valid_hold", 32'(sample_valid), 1);
            chk("t3_sample_hold", 32'(sample), 32'hAAAA);
            chk("t3_no_read", 32'(flash_mem_read), 0);
        end
        chk("t3_one_accept", 32'(accepts - a0), 1);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("t3_second_half", 32'(sample), 32'hBBBB);
        chk("t3_second_valid", 32'(sample_valid), 1);
        repeat (2) begin
            @(negedge clk);
            chk("t3_b_no_read", 32'(flash_mem_read), 0);
            chk("t3_b_hold", 32'(sample), 32'hBBBB);
        end
        chk("t3_still_one", 32'(accepts - a0), 1);
        sample_ready = 1'b1;
        wait_idle("t3_idle", 40);
        chk("t3_nsamp", 32'(samp_q.size() - s0), 4);
        chk("t3_s2", 32'(samp_q[s0+2]), 32'hCCCC);
        chk("t3_s3", 32'(samp_q[s0+3]), 32'hDDDD);

        // single-word loop, then stop during WAIT_DATA
        a0 = accepts; d0 = done_cnt; l0 = addr_log.size();
        play(23'h20, 23'h20, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_rereads", 32'(accepts - a0 >= 3), 1);
        all20 = 1'b1;
        for (int i = l0; i < addr_log.size(); i++) if (addr_log[i] != 23'h20) all20 = 1'b0;
        chk("t4_all_0x20", 32'(all20), 1);
        chk("t4_no_done", 32'(done_cnt - d0), 0);
        chk("t4_busy", 32'(busy), 1);
        n = 0;
        while (flash_mem_read !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("t4_req_seen", 32'(flash_mem_read), 1);
        @(negedge clk);
        chk("t4_in_wait", 32'(flash_mem_read), 0);
        stop = 1'b1;
        s1 = samp_q.size(); a1 = accepts;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_stop_idle", 32'(busy), 0);
        chk("t4_stop_valid", 32'(sample_valid), 0);
        repeat (4) @(negedge clk);
        chk("t4_discarded", 32'(samp_q.size() - s1), 0);
        chk("t4_no_more_reads", 32'(accepts - a1), 0);
        chk("t4_no_done_abort", 32'(done_cnt - d0), 0);

        // dir = 1 over 0x01 -> 0x00
        s0 = samp_q.size(); d0 = done_cnt; l0 = addr_log.size();
        play(23'h01, 23'h00, 1'b0, 1'b1);
`ifdef FLASH_SEQ_REVERSE_EN
        wait_idle("t5_idle", 40);
        chk("t5_s0", 32'(samp_q[s0]), 32'h2222);
        chk("t5_s1", 32'(samp_q[s0+1]), 32'h1111);
        chk("t5_s2", 32'(samp_q[s0+2]), 32'h4444);
        chk("t5_s3", 32'(samp_q[s0+3]), 32'h3333);
        chk("t5_a0", 32'(addr_log[l0]), 32'h01);
        chk("t5_a1", 32'(addr_log[l0+1]), 32'h00);
        chk("t5_ndone", 32'(done_cnt - d0), 1);
`else
        n = 0;
        while (samp_q.size() < s0 + 3 && n < 40) begin @(negedge clk); n++; end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t5_idle", 20);
        chk("t5_s0", 32'(samp_q[s0]), 32'h1111);
        chk("t5_s1", 32'(samp_q[s0+1]), 32'h2222);
        chk("t5_s2", 32'(samp_q[s0+2]), 32'h0002);
        chk("t5_a0", 32'(addr_log[l0]), 32'h01);
        chk("t5_a1", 32'(addr_log[l0+1]), 32'h02);
        chk("t5_no_done", 32'(done_cnt - d0), 0);
`endif

        // asynchronous reset in EMIT_B, then a clean restart
        sample_ready = 1'b0;
        play(23'h10, 23'h11, 1'b0, 1'b0);
        wait_valid("t6_valid", 20);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("t6_in_emit_b", 32'(sample), 32'hBBBB);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_read", 32'(flash_mem_read), 0);
        chk("t6_rst_valid", 32'(sample_valid), 0);
        chk("t6_rst_addr", 32'(flash_mem_address), 0);
        chk("t6_rst_sample", 32'(sample), 0);
        @(negedge clk);
        reset = 1'b0;
        sample_ready = 1'b1;
        @(negedge clk);
        s0 = samp_q.size(); a0 = accepts; d0 = done_cnt; l0 = addr_log.size();
        play(23'h11, 23'h11, 1'b0, 1'b0);
        chk("t6_addr", 32'(flash_mem_address), 32'h11);
        chk("t6_read", 32'(flash_mem_read), 1);
        wait_idle("t6_idle", 40);
        chk("t6_nsamp", 32'(samp_q.size() - s0), 2);
        chk("t6_s0", 32'(samp_q[s0]), 32'hCCCC);
        chk("t6_s1", 32'(samp_q[s0+1]), 32'hDDDD);
        chk("t6_a0", 32'(addr_log[l0]), 32'h11);
        chk("t6_ndone", 32'(done_cnt - d0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
